// File: rtl/vi_rst_seq_pkg.sv
// vi_rst_seq_pkg: shared state encoding and counter sizing for the reset sequencer
package vi_rst_seq_pkg;
    localparam int MAX_PARAM  = 1023;
    localparam int MAX_STAGES = 8;
    localparam int CNT_W      = $clog2(MAX_PARAM + 1);
    localparam int IDX_W      = $clog2(MAX_STAGES);
    typedef enum logic [2:0] {
        ST_WAIT_LOCK = 3'd0,
        ST_HOLD      = 3'd1,
        ST_STAGE     = 3'd2,
        ST_RUN       = 3'd3
    } state_e;
endpackage

// File: rtl/vi_bit_sync.sv
// vi_bit_sync: two-flop single-bit synchronizer with configurable reset value
module vi_bit_sync #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic q_o
);
    logic meta_q;
    logic sync_q;
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end
    assign q_o = sync_q;
endmodule

// File: rtl/vi_rst_seq.sv
// vi_rst_seq: lock-qualified, ordered release of downstream resets with soft reset and lock-loss handling
module vi_rst_seq
    import vi_rst_seq_pkg::*;
#(
    parameter int NUM_STAGES  = 4,
    parameter int LOCK_FILTER = 32,
    parameter int HOLD_CYCLES = 16,
    parameter int STAGE_GAP   = 8
) (
    input  logic                  iCLK,
    input  logic                  iRST,
    input  logic                  iPLL_LOCKED,
    input  logic                  iSOFT_RST_REQ,
    output logic [NUM_STAGES-1:0] oRST_N,
    output logic                  oSOFT_RST_ACK,
    output logic                  oDONE,
    output logic                  oLOCK_LOSS,
    output logic [2:0]            oSTATE
);
    logic                  lock_s;
    state_e                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d, cnt_inc;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [NUM_STAGES-1:0] rst_n_q, rst_n_d;
    logic                  pend_q, pend_d;
    logic                  done_q, done_d;
    logic                  ack_q, ack_d;
    logic                  loss_q, loss_d;
    logic                  lock_lost;

    vi_bit_sync #(.RST_VAL(1'b0)) u_lock_sync (
        .clk_i (iCLK),
        .rst_i (iRST),
        .d_i   (iPLL_LOCKED),
        .q_o   (lock_s)
    );

    assign cnt_inc   = cnt_q + CNT_W'(1);
    assign lock_lost = (state_q != ST_WAIT_LOCK) && !lock_s;

    // Lock loss pre-empts every other transition, including a pending soft reset.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        idx_d   = idx_q;
        rst_n_d = rst_n_q;
        done_d  = 1'b0;
        ack_d   = 1'b0;
        loss_d  = 1'b0;
        pend_d  = pend_q | iSOFT_RST_REQ;
        if (lock_lost) begin
            state_d = ST_WAIT_LOCK;
            rst_n_d = '0;
            loss_d  = 1'b1;
        end else begin
            case (state_q)
                ST_WAIT_LOCK: begin
                    rst_n_d = '0;
                    if (lock_s) begin
                        if (cnt_inc == CNT_W'(LOCK_FILTER)) state_d = ST_HOLD;
                        else cnt_d = cnt_inc;
                    end
                end
                ST_HOLD: begin
                    rst_n_d = '0;
                    if (cnt_inc == CNT_W'(HOLD_CYCLES)) begin
                        state_d = ST_STAGE;
                        idx_d   = '0;
                        rst_n_d = NUM_STAGES'(1);
                    end else cnt_d = cnt_inc;
                end
                ST_STAGE: begin
                    if (cnt_inc == CNT_W'(STAGE_GAP)) begin
                        if (idx_q == IDX_W'(NUM_STAGES - 1)) begin
                            state_d = ST_RUN;
                            done_d  = 1'b1;
                        end else begin
                            idx_d   = idx_q + IDX_W'(1);
                            rst_n_d = rst_n_q | (NUM_STAGES'(1) << (idx_q + IDX_W'(1)));
                        end
                    end else cnt_d = cnt_inc;
                end
                ST_RUN: begin
                    if (pend_q) begin
                        state_d = ST_HOLD;
                        rst_n_d = '0;
                        ack_d   = 1'b1;
                        pend_d  = iSOFT_RST_REQ;
                    end else done_d = 1'b1;
                end
                default: begin
                    state_d = ST_WAIT_LOCK;
                    rst_n_d = '0;
                end
            endcase
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q <= ST_WAIT_LOCK;
            cnt_q   <= '0;
            idx_q   <= '0;
            rst_n_q <= '0;
            pend_q  <= 1'b0;
            done_q  <= 1'b0;
            ack_q   <= 1'b0;
            loss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            rst_n_q <= rst_n_d;
            pend_q  <= pend_d;
            done_q  <= done_d;
            ack_q   <= ack_d;
            loss_q  <= loss_d;
        end
    end

    assign oRST_N        = rst_n_q;
    assign oSOFT_RST_ACK = ack_q;
    assign oDONE         = done_q;
    assign oLOCK_LOSS    = loss_q;
    assign oSTATE        = state_q;
endmodule

// File: tb/tb_vi_rst_seq.sv
// tb_vi_rst_seq: directed checks of the reset sequencer at default parameters
module tb_vi_rst_seq;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pll = 1'b0;
    logic       req = 1'b0;
    logic [3:0] rst_n;
    logic       ack, done, loss;
    logic [2:0] state;
    int         vec = 0;
    int         miscmp = 0;

    vi_rst_seq dut (
        .iCLK          (clk),
        .iRST          (rst),
        .iPLL_LOCKED   (pll),
        .iSOFT_RST_REQ (req),
        .oRST_N        (rst_n),
        .oSOFT_RST_ACK (ack),
        .oDONE         (done),
        .oLOCK_LOSS    (loss),
        .oSTATE        (state)
    );

    always #5 clk = ~clk;

    task automatic adv(input int n);
        repeat (n) @(negedge clk);
    endtask

    // expected oRST_N k cycles after HOLD entry (k<0 means not yet in HOLD)
    function automatic logic [3:0] seq_rst(input int k);
        return k < 16 ? 4'h0 : k < 24 ? 4'h1 : k < 32 ? 4'h3 : k < 40 ? 4'h7 : 4'hf;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        pll = 1'b0;
        req = 1'b0;
        adv(3);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        pll = 1'b1;
        adv(3);
        vec++;
        if ({rst_n, done, ack, loss, state} !== {4'h0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            miscmp++;
            $display("FAIL reset: got rst_n=%b done=%b ack=%b loss=%b state=%0d, want 0000/0/0/0/0", rst_n, done, ack, loss, state);
        end
        rst = 1'b0;
    endtask

    task automatic test_full_sequence();
        logic [3:0] er;
        logic [2:0] es;
        do_reset();
        pll = 1'b1;
        for (int c = 1; c <= 90; c++) begin
            adv(1);
            er = seq_rst(c - 34);
            es = c < 34 ? 3'd0 : c < 50 ? 3'd1 : c < 82 ? 3'd2 : 3'd3;
            vec++;
            if ({rst_n, done, state, ack, loss} !== {er, c >= 82, es, 1'b0, 1'b0}) begin
                miscmp++;
                $display("FAIL full_seq c=%0d: got rst_n=%b done=%b state=%0d ack=%b loss=%b, want %b/%b/%0d/0/0", c, rst_n, done, state, ack, loss, er, c >= 82, es);
            end
        end
    endtask

    task automatic test_glitch();
        do_reset();
        pll = 1'b1;
        adv(22);
        pll = 1'b0;
        adv(1);
        pll = 1'b1;
        adv(11);
        vec++;
        if (state !== 3'd0) begin
            miscmp++;
            $display("FAIL glitch_early c=34: got state=%0d, want 0", state);
        end
        adv(22);
        vec++;
        if (state !== 3'd0) begin
            miscmp++;
            $display("FAIL glitch_pre c=56: got state=%0d, want 0", state);
        end
        adv(1);
        vec++;
        if ({state, rst_n} !== {3'd1, 4'h0}) begin
            miscmp++;
            $display("FAIL glitch_hold c=57: got state=%0d rst_n=%b, want 1/0000", state, rst_n);
        end
    endtask

    task automatic run_to_run();
        do_reset();
        pll = 1'b1;
        adv(82);
    endtask

    task automatic test_lock_loss_run();
        run_to_run();
        pll = 1'b0;
        adv(2);
        vec++;
        if ({rst_n, done, loss, state} !== {4'hf, 1'b1, 1'b0, 3'd3}) begin
            miscmp++;
            $display("FAIL loss_pre: got rst_n=%b done=%b loss=%b state=%0d, want 1111/1/0/3", rst_n, done, loss, state);
        end
        adv(1);
        vec++;
        if ({rst_n, done, loss, state} !== {4'h0, 1'b0, 1'b1, 3'd0}) begin
            miscmp++;
            $display("FAIL loss_edge: got rst_n=%b done=%b loss=%b state=%0d, want 0000/0/1/0", rst_n, done, loss, state);
        end
        adv(1);
        vec++;
        if ({loss, state} !== {1'b0, 3'd0}) begin
            miscmp++;
            $display("FAIL loss_pulse: got loss=%b state=%0d, want 0/0", loss, state);
        end
    endtask

    // pulses at cycles p0 and p1; acks expected at a0 and (if a1>0) a1
    task automatic soft_scenario(input string name, input int p0, input int p1, input int a0, input int a1);
        logic [3:0] er;
        logic       ed;
        int         h;
        do_reset();
        pll = 1'b1;
        for (int c = 1; c <= 185; c++) begin
            req = (c == p0) || (c == p1);
            adv(1);
            h = (a1 > 0 && c >= a1) ? a1 : (c >= a0) ? a0 : 34;
            er = seq_rst(c - h);
            ed = (c - h) >= 48;
            vec++;
            if ({ack, rst_n, done} !== {(c == a0) || (c == a1), er, ed}) begin
                miscmp++;
                $display("FAIL %s c=%0d: got ack=%b rst_n=%b done=%b, want %b/%b/%b", name, c, ack, rst_n, done, (c == a0) || (c == a1), er, ed);
            end
        end
        req = 1'b0;
    endtask

    task automatic test_soft_reset();
        soft_scenario("soft_merge", 61, 71, 83, 0);
    endtask

    task automatic test_back_to_back();
        soft_scenario("soft_b2b", 61, 83, 83, 132);
    endtask

    task automatic test_soft_and_loss();
        run_to_run();
        pll = 1'b0;
        adv(1);
        req = 1'b1;
        adv(1);
        req = 1'b0;
        adv(1);
        vec++;
        if ({loss, ack, state, rst_n} !== {1'b1, 1'b0, 3'd0, 4'h0}) begin
            miscmp++;
            $display("FAIL soft_loss_edge: got loss=%b ack=%b state=%0d rst_n=%b, want 1/0/0/0000", loss, ack, state, rst_n);
        end
        pll = 1'b1;
        for (int k = 1; k <= 84; k++) begin
            adv(1);
            vec++;
            if ({ack, done} !== {k == 83, k == 82}) begin
                miscmp++;
                $display("FAIL soft_loss_resume k=%0d: got ack=%b done=%b, want %b/%b", k, ack, done, k == 83, k == 82);
            end
        end
    endtask

    task automatic test_reset_mid_stage();
        do_reset();
        pll = 1'b1;
        adv(68);
        vec++;
        if ({rst_n, state} !== {4'h7, 3'd2}) begin
            miscmp++;
            $display("FAIL mid_pre: got rst_n=%b state=%0d, want 0111/2", rst_n, state);
        end
        rst = 1'b1;
        adv(1);
        rst = 1'b0;
        vec++;
        if ({rst_n, done, ack, loss, state} !== {4'h0, 1'b0, 1'b0, 1'b0, 3'd0}) begin
            miscmp++;
            $display("FAIL mid_rst: got rst_n=%b done=%b ack=%b loss=%b state=%0d, want 0000/0/0/0/0", rst_n, done, ack, loss, state);
        end
        for (int k = 1; k <= 82; k++) begin
            adv(1);
            vec++;
            if ({rst_n, done, state == 3'd0} !== {seq_rst(k - 34), k >= 82, k < 34}) begin
                miscmp++;
                $display("FAIL mid_restart k=%0d: got rst_n=%b done=%b state=%0d, want %b/%b", k, rst_n, done, state, seq_rst(k - 34), k >= 82);
            end
        end
    endtask

    initial begin
        test_reset();
        test_full_sequence();
        test_glitch();
        test_lock_loss_run();
        test_soft_reset();
        test_back_to_back();
        test_soft_and_loss();
        test_reset_mid_stage();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miscmp);
        $finish;
    end
endmodule
